// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time imem loader.
package imem_loader_pkg;

  // Framing states: two header bytes, payload words, checksum, then a
  // terminal state that waits for iStart.
  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem word write port of the loader.
interface imem_loader_if #(
  parameter int AW = 32
);
  logic [7:0]    iByte;
  logic          iValid;
  logic          oReady;
  logic          oWe;
  logic [AW-1:0] oAddr;
  logic [31:0]   oWdata;

  // Host side: feeds bytes, observes the write port.
  modport master (
    output iByte, iValid,
    input  oReady, oWe, oAddr, oWdata
  );

  // Loader side.
  modport slave (
    input  iByte, iValid,
    output oReady, oWe, oAddr, oWdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts big-endian bytes into 32-bit words, keeps the XOR checksum of
// all payload bytes and strobes word_vld the cycle after the 4th byte.
import imem_loader_pkg::*;

module imem_loader_byte_packer (
  input  logic        iClk,
  input  logic        iResetN,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_vld,
  output logic [7:0]  csum,
  output logic        last_byte
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      sh;

  assign last_byte = (idx == IDX_W'(WORD_BYTES - 1));

  // Byte index, partial word, checksum and the one-cycle word strobe.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      idx      <= '0;
      sh       <= '0;
      word     <= '0;
      word_vld <= 1'b0;
      csum     <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clr) begin
        idx  <= '0;
        sh   <= '0;
        csum <= '0;
      end else if (take) begin
        csum <= csum ^ din;
        sh   <= {sh[15:0], din};
        idx  <= idx + IDX_W'(1);
        if (last_byte) begin
          word     <= {sh, din};
          word_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream (header count, big-endian words,
// XOR checksum), writes words into imem from address 0 and holds the
// core in reset until a checksum-clean image has landed.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int MAX_WORDS = 64,
  parameter int AW        = 32
) (
  input  logic          iClk,
  input  logic          iResetN,
  input  logic          iStart,
  imem_loader_if.slave  bus,
  output logic          oDone,
  output logic          oError,
  output logic          oCpuReset
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  ld_state_t     state, nxt;
  logic [15:0]   count;
  logic [15:0]   hdr;
  logic [CW-1:0] wcnt;
  logic [AW-1:0] addr;
  logic          acc;
  logic          restart;
  logic          last_word;
  logic          csum_ok;
  logic          pk_clr;
  logic          pk_take;
  logic          pk_last;
  logic          pk_vld;
  logic [31:0]   pk_word;
  logic [7:0]    pk_csum;

  assign acc       = bus.iValid && bus.oReady;
  assign restart   = iStart && (state == DONE || state == ERR);
  assign hdr       = {count[15:8], bus.iByte};
  assign last_word = (16'(wcnt) + 16'd1) == count;
  assign csum_ok   = (bus.iByte == pk_csum);

  // Checksum restarts with each new header; index restarts on iStart.
  assign pk_clr  = restart || (state == HDR_HI && acc);
  assign pk_take = acc && (state == DATA);

  imem_loader_byte_packer u_pack (
    .iClk      (iClk),
    .iResetN   (iResetN),
    .clr       (pk_clr),
    .take      (pk_take),
    .din       (bus.iByte),
    .word      (pk_word),
    .word_vld  (pk_vld),
    .csum      (pk_csum),
    .last_byte (pk_last)
  );

  assign bus.oWe    = pk_vld;
  assign bus.oWdata = pk_word;
  assign bus.oAddr  = addr;

  // State register.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) state <= HDR_HI;
    else          state <= nxt;
  end

  // Next state and ready; ready depends on state only.
  always_comb begin
    nxt        = state;
    bus.oReady = 1'b0;
    case (state)
      HDR_HI: begin
        bus.oReady = 1'b1;
        if (acc) nxt = HDR_LO;
      end
      HDR_LO: begin
        bus.oReady = 1'b1;
        if (acc) begin
          if (hdr > 16'(MAX_WORDS)) nxt = ERR;
          else if (hdr == 16'd0)    nxt = CSUM;
          else                      nxt = DATA;
        end
      end
      DATA: begin
        bus.oReady = 1'b1;
        if (acc && pk_last && last_word) nxt = CSUM;
      end
      CSUM: begin
        bus.oReady = 1'b1;
        if (acc) nxt = csum_ok ? DONE : ERR;
      end
      DONE, ERR: begin
        if (iStart) nxt = HDR_HI;
      end
      default: nxt = HDR_HI;
    endcase
  end

  // Header count, word counter, write address and status flags.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      count     <= '0;
      wcnt      <= '0;
      addr      <= '0;
      oDone     <= 1'b0;
      oError    <= 1'b0;
      oCpuReset <= 1'b1;
    end else if (restart) begin
      count     <= '0;
      wcnt      <= '0;
      addr      <= '0;
      oDone     <= 1'b0;
      oError    <= 1'b0;
      oCpuReset <= 1'b1;
    end else begin
      case (state)
        HDR_HI: if (acc) count[15:8] <= bus.iByte;
        HDR_LO: if (acc) begin
          count[7:0] <= bus.iByte;
          if (hdr > 16'(MAX_WORDS)) oError <= 1'b1;
        end
        DATA: if (acc && pk_last) wcnt <= wcnt + CW'(1);
        CSUM: if (acc) begin
          if (csum_ok) begin
            oDone     <= 1'b1;
            oCpuReset <= 1'b0;
          end else begin
            oError    <= 1'b1;
          end
        end
        default: ;
      endcase
      // A pulse seen while still in DATA means more words follow; the
      // final word always pulses in CSUM, so the address stops there.
      if (pk_vld && state == DATA) addr <= addr + AW'(WORD_BYTES);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-accurate vector table plus
// hand-written sequences for gaps, mid-load reset and restart.
module tb_imem_loader;

  logic iClk = 1'b0;
  logic iResetN;
  logic iStart;
  logic oDone, oError, oCpuReset;

  imem_loader_if #(.AW(32)) bus();

  imem_loader #(.MAX_WORDS(64), .AW(32)) dut (
    .iClk      (iClk),
    .iResetN   (iResetN),
    .iStart    (iStart),
    .bus       (bus),
    .oDone     (oDone),
    .oError    (oError),
    .oCpuReset (oCpuReset)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        s;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] wa[$];
  logic [31:0] wv[$];

  // Record every write pulse once, mid-cycle.
  always @(negedge iClk) begin
    if (bus.oWe) begin
      wa.push_back(bus.oAddr);
      wv.push_back(bus.oWdata);
    end
  end

  task automatic add(input logic v, input logic [7:0] b, input logic s,
                     input logic rdy, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic dn, input logic er,
                     input logic cr);
    vec_t r;
    r.v = v; r.b = b; r.s = s; r.rdy = rdy; r.we = we; r.addr = addr;
    r.wd = wd; r.dn = dn; r.er = er; r.cr = cr;
    vecs.push_back(r);
  endtask

  // Two-word image 0x20080005, 0xAC080004 at full rate, then checksum cs.
  task automatic add_img(input logic [7:0] cs, input logic good,
                         input logic [31:0] wd0);
    add(1, 8'h00, 0, 1, 0, 0, wd0, 0, 0, 1);
    add(1, 8'h02, 0, 1, 0, 0, wd0, 0, 0, 1);
    add(1, 8'h20, 0, 1, 0, 0, wd0, 0, 0, 1);
    add(1, 8'h08, 0, 1, 0, 0, wd0, 0, 0, 1);
    add(1, 8'h00, 0, 1, 0, 0, wd0, 0, 0, 1);
    add(1, 8'h05, 0, 1, 1, 0, 32'h20080005, 0, 0, 1);
    add(1, 8'hAC, 0, 1, 0, 4, 32'h20080005, 0, 0, 1);
    add(1, 8'h08, 0, 1, 0, 4, 32'h20080005, 0, 0, 1);
    add(1, 8'h00, 0, 1, 0, 4, 32'h20080005, 0, 0, 1);
    add(1, 8'h04, 0, 1, 1, 4, 32'hAC080004, 0, 0, 1);
    add(1, cs,    0, 0, 0, 4, 32'hAC080004, good, !good, !good);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic rdy, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic dn, input logic er, input logic cr);
    logic [67:0] g, e;
    g = {bus.oReady, bus.oWe, bus.oAddr, bus.oWdata, oDone, oError, oCpuReset};
    e = {rdy, we, addr, wd, dn, er, cr};
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got rdy=%b we=%b addr=%h wd=%h dn=%b er=%b cr=%b exp rdy=%b we=%b addr=%h wd=%h dn=%b er=%b cr=%b",
               name, bus.oReady, bus.oWe, bus.oAddr, bus.oWdata, oDone, oError,
               oCpuReset, rdy, we, addr, wd, dn, er, cr);
    end
  endtask

  // Offer one byte after 'gap' idle cycles; bounded wait on oReady.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.iValid = 1'b0;
    repeat (gap) begin @(posedge iClk); #1; end
    bus.iValid = 1'b1;
    bus.iByte  = b;
    while (!bus.oReady && n < 20) begin @(posedge iClk); #1; n++; end
    if (!bus.oReady) begin
      total++;
      bad++;
      $display("FAIL send_timeout byte=%h", b);
    end else begin
      @(posedge iClk); #1;
    end
    bus.iValid = 1'b0;
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  logic [31:0] gw [3];
  logic [7:0]  wb;

  initial begin
    iResetN    = 1'b0;
    iStart     = 1'b0;
    bus.iValid = 1'b0;
    bus.iByte  = 8'h00;
    repeat (2) @(posedge iClk);
    #1;
    chk_outs("reset_state", 1, 0, 0, 0, 0, 0, 1);
    iResetN = 1'b1;
    @(posedge iClk); #1;

    // Good image: payload XOR = 0x2D ^ 0xA0 = 0x8D.
    add_img(8'h8D, 1'b1, 32'h0);
    add(1, 8'hFF, 0, 0, 0, 4, 32'hAC080004, 1, 0, 0);   // ignored in DONE
    add(0, 8'h00, 1, 1, 0, 0, 32'hAC080004, 0, 0, 1);   // restart
    // Same image, wrong checksum.
    add_img(8'h00, 1'b0, 32'hAC080004);
    add(0, 8'h00, 1, 1, 0, 0, 32'hAC080004, 0, 0, 1);
    // Count 65: iStart outside DONE/ERR must be ignored.
    add(1, 8'h00, 1, 1, 0, 0, 32'hAC080004, 0, 0, 1);
    add(1, 8'h41, 0, 0, 0, 0, 32'hAC080004, 0, 1, 1);
    add(0, 8'h00, 1, 1, 0, 0, 32'hAC080004, 0, 0, 1);
    // Count 0, checksum 0.
    add(1, 8'h00, 0, 1, 0, 0, 32'hAC080004, 0, 0, 1);
    add(1, 8'h00, 0, 1, 0, 0, 32'hAC080004, 0, 0, 1);
    add(1, 8'h00, 0, 0, 0, 0, 32'hAC080004, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 32'hAC080004, 0, 0, 1);

    foreach (vecs[i]) begin
      bus.iValid = vecs[i].v;
      bus.iByte  = vecs[i].b;
      iStart     = vecs[i].s;
      @(posedge iClk); #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].addr,
               vecs[i].wd, vecs[i].dn, vecs[i].er, vecs[i].cr);
    end
    bus.iValid = 1'b0;
    iStart     = 1'b0;

    // Three words with random gaps; checksum 0x44 ^ 0x22 ^ 0xC9 = 0xAF.
    gw[0] = 32'h11223344; gw[1] = 32'hDEADBEEF; gw[2] = 32'hCAFEF00D;
    wa.delete(); wv.delete();
    send(8'h00, $urandom_range(0, 3));
    send(8'h03, $urandom_range(0, 3));
    for (int w = 0; w < 3; w++) begin
      for (int k = 3; k >= 0; k--) begin
        wb = gw[w][8*k +: 8];
        send(wb, $urandom_range(0, 3));
      end
    end
    send(8'hAF, $urandom_range(0, 3));
    repeat (2) begin @(posedge iClk); #1; end
    chk("gap_nwrites", wa.size(), 3);
    for (int w = 0; w < 3; w++) begin
      if (w < wa.size()) begin
        chk($sformatf("gap_addr%0d", w), wa[w], 32'(4 * w));
        chk($sformatf("gap_data%0d", w), wv[w], gw[w]);
      end
    end
    chk("gap_done", {oDone, oError, oCpuReset}, 3'b100);
    chk("gap_last_addr", bus.oAddr, 32'h8);

    // Mid-load asynchronous reset after six payload bytes.
    pulse_start();
    wa.delete(); wv.delete();
    send(8'h00, 0); send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'hAC, 0); send(8'h08, 0);
    chk("pre_rst_addr", bus.oAddr, 32'h4);
    #3 iResetN = 1'b0;
    #1;
    chk_outs("async_reset", 1, 0, 0, 0, 0, 0, 1);
    @(posedge iClk); #1;
    iResetN = 1'b1;
    wa.delete(); wv.delete();
    // One word 0x8C090008, checksum 0x8C ^ 0x09 ^ 0x08 = 0x8D.
    send(8'h00, 0); send(8'h01, 0);
    send(8'h8C, 0); send(8'h09, 1); send(8'h00, 0); send(8'h08, 2);
    send(8'h8D, 0);
    repeat (2) begin @(posedge iClk); #1; end
    chk("reload_nwrites", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("reload_addr", wa[0], 32'h0);
      chk("reload_data", wv[0], 32'h8C090008);
    end
    chk("reload_done", {oDone, oError, oCpuReset}, 3'b100);

    // Restart from DONE and load 0x01234567, checksum 0x00.
    pulse_start();
    chk_outs("restart", 1, 0, 0, 32'h8C090008, 0, 0, 1);
    wa.delete(); wv.delete();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h01, 0); send(8'h23, 0); send(8'h45, 0); send(8'h67, 0);
    send(8'h00, 0);
    repeat (2) begin @(posedge iClk); #1; end
    chk("restart_nwrites", wa.size(), 1);
    if (wa.size() > 0) begin
      chk("restart_addr", wa[0], 32'h0);
      chk("restart_data", wv[0], 32'h01234567);
    end
    chk("restart_done", {oDone, oError, oCpuReset}, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
